if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit_pkg.sv | 10 +
 rtl/if_fetch_unit_hold_buf.sv | 16 +
 rtl/if_fetch_unit.sv | 69 ++++++
 tb/tb_if_fetch_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared constants and br_bus field layout for the fetch stage
package if_fetch_unit_pkg;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int IF_TO_ID_BUS_W = 64;
  localparam int BR_BUS_W = 34;
  localparam int BR_TAKEN_BIT = 33;
  localparam int BR_TARGET_MSB = 32;
  localparam int BR_TARGET_LSB = 1;
  localparam int BR_STALL_BIT = 0;
endpackage

// File: rtl/if_fetch_unit_hold_buf.sv
// if_inst_hold_buf: holds the SRAM read data while ID stalls so the bus stays stable
module if_inst_hold_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] din,
  output logic        buf_valid,
  output logic [31:0] inst_buf
);
  always_ff @(posedge clk) begin
    if (reset || clear) buf_valid <= 1'b0;
    else if (capture) buf_valid <= 1'b1;
    if (capture && !clear && !reset) inst_buf <= din;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: pre-IF/IF stage generating nextpc, driving inst SRAM and presenting {pc,inst} to ID
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = if_fetch_unit_pkg::RESET_PC
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     ID_Allow_in,
  input  logic [if_fetch_unit_pkg::BR_BUS_W-1:0]   br_bus,
  output logic                                     IF_to_ID_Valid,
  output logic [if_fetch_unit_pkg::IF_TO_ID_BUS_W-1:0] IF_to_ID_Bus,
  output logic                                     inst_sram_en,
  output logic [3:0]                               inst_sram_we,
  output logic [31:0]                              inst_sram_addr,
  output logic [31:0]                              inst_sram_wdata,
  input  logic [31:0]                              inst_sram_rdata
);
  import if_fetch_unit_pkg::*;
  logic        fs_valid;
  logic        fresh;
  logic        buf_valid;
  logic [31:0] pc;
  logic [31:0] inst_buf;
  logic [31:0] nextpc;
  logic [31:0] br_target;
  logic [31:0] inst;
  logic        br_taken;
  logic        fs_ready_go;
  logic        fs_allow_in;
  logic        handoff;
  logic        capture;
  logic        unused_stall;
  assign br_taken     = br_bus[BR_TAKEN_BIT];
  assign br_target    = br_bus[BR_TARGET_MSB:BR_TARGET_LSB];
  assign unused_stall = br_bus[BR_STALL_BIT];
  assign nextpc       = br_taken ? br_target : pc + 32'd4;
  assign fs_ready_go  = fs_valid & (fresh | buf_valid);
  assign fs_allow_in  = ~fs_valid | (fs_ready_go & ID_Allow_in) | br_taken;
  assign inst_sram_en    = ~reset & fs_allow_in;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_wdata = 32'b0;
  assign inst           = buf_valid ? inst_buf : inst_sram_rdata;
  assign IF_to_ID_Valid = ~reset & fs_valid & fs_ready_go & ~br_taken;
  assign IF_to_ID_Bus   = {pc, inst};
  assign handoff = IF_to_ID_Valid & ID_Allow_in;
  assign capture = fresh & fs_valid & ~ID_Allow_in & ~br_taken;
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid <= 1'b0;
      fresh    <= 1'b0;
      pc       <= RESET_PC - 32'd4;
    end else if (inst_sram_en) begin
      fs_valid <= 1'b1;
      fresh    <= 1'b1;
      pc       <= nextpc;
    end else begin
      fresh    <= 1'b0;
    end
  end
  if_inst_hold_buf u_hold_buf (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .clear     (handoff | br_taken),
    .din       (inst_sram_rdata),
    .buf_valid (buf_valid),
    .inst_buf  (inst_buf)
  );
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized and directed checks of if_fetch_unit against a behavioural fetch model
module tb_if_fetch_unit;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;
  localparam logic [31:0] RPC = 32'h1c000000;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ID_Allow_in = 1'b1;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'b0;
  logic        br_stall = 1'b0;
  logic [33:0] br_bus;
  logic        IF_to_ID_Valid;
  logic [63:0] IF_to_ID_Bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        ram_en_q = 1'b0;
  logic [31:0] ram_addr_q = 32'b0;
  logic [31:0] junk = 32'hdeadbeef;
  int total = 0;
  int bad = 0;
  bit   m_live = 1'b0;
  bit   m_valid = 1'b0;
  logic [31:0] m_pc = RPC - 32'd4;
  assign br_bus = {br_taken, br_target, br_stall};
  always #5 clk = ~clk;
  if_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .ID_Allow_in     (ID_Allow_in),
    .br_bus          (br_bus),
    .IF_to_ID_Valid  (IF_to_ID_Valid),
    .IF_to_ID_Bus    (IF_to_ID_Bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );
  always @(posedge clk) begin
    ram_en_q   <= inst_sram_en;
    ram_addr_q <= inst_sram_addr;
    junk       <= $urandom;
  end
  assign inst_sram_rdata = ram_en_q ? (ram_addr_q ^ KEY) : junk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (m_live) begin
      automatic bit e_en = !reset && (!m_valid || ID_Allow_in || br_taken);
      automatic bit e_vld = !reset && m_valid && !br_taken;
      chk("m_en", 64'(inst_sram_en), 64'(e_en));
      chk("m_valid", 64'(IF_to_ID_Valid), 64'(e_vld));
      chk("m_tied", {28'b0, inst_sram_we, inst_sram_wdata}, 64'b0);
      if (!reset) chk("m_addr", 64'(inst_sram_addr), 64'(br_taken ? br_target : m_pc + 32'd4));
      if (e_vld) chk("m_bus", IF_to_ID_Bus, {m_pc, m_pc ^ KEY});
    end
  end
  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b0;
      m_pc    = RPC - 32'd4;
      m_live  = 1'b1;
    end else if (!m_valid || ID_Allow_in || br_taken) begin
      m_pc    = br_taken ? br_target : m_pc + 32'd4;
      m_valid = 1'b1;
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic look();
    #3;
  endtask
  initial begin
    cyc();
    cyc();
    reset = 1'b0;
    look();
    chk("t1_en", 64'(inst_sram_en), 64'd1);
    chk("t1_addr0", 64'(inst_sram_addr), 64'h1c000000);
    chk("t1_valid0", 64'(IF_to_ID_Valid), 64'd0);
    cyc();
    look();
    chk("t1_valid1", 64'(IF_to_ID_Valid), 64'd1);
    chk("t1_bus", IF_to_ID_Bus, 64'h1c000000_B9A5A5A5);
    chk("t1_addr1", 64'(inst_sram_addr), 64'h1c000004);
    cyc();
    cyc();
    ID_Allow_in = 1'b0;
    look();
    chk("t2_pc", IF_to_ID_Bus[63:32], 64'h1c000008);
    chk("t2_en0", 64'(inst_sram_en), 64'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      look();
      chk("t2_hold_en", 64'(inst_sram_en), 64'd0);
      chk("t2_hold_bus", IF_to_ID_Bus, {32'h1c000008, 32'h1c000008 ^ KEY});
    end
    cyc();
    ID_Allow_in = 1'b1;
    look();
    chk("t2_rel_bus", IF_to_ID_Bus, {32'h1c000008, 32'h1c000008 ^ KEY});
    chk("t2_rel_addr", 64'(inst_sram_addr), 64'h1c00000c);
    cyc();
    look();
    chk("t2_next_pc", IF_to_ID_Bus[63:32], 64'h1c00000c);
    cyc();
    br_taken = 1'b1;
    br_target = 32'h1c000100;
    look();
    chk("t3_pc", IF_to_ID_Bus[63:32], 64'h1c000010);
    chk("t3_valid", 64'(IF_to_ID_Valid), 64'd0);
    chk("t3_en", 64'(inst_sram_en), 64'd1);
    chk("t3_addr", 64'(inst_sram_addr), 64'h1c000100);
    cyc();
    br_taken = 1'b0;
    ID_Allow_in = 1'b0;
    look();
    chk("t3_bus", IF_to_ID_Bus, {32'h1c000100, 32'h1c000100 ^ KEY});
    cyc();
    br_taken = 1'b1;
    br_target = 32'h1c000180;
    look();
    chk("t4_valid", 64'(IF_to_ID_Valid), 64'd0);
    chk("t4_en", 64'(inst_sram_en), 64'd1);
    chk("t4_addr", 64'(inst_sram_addr), 64'h1c000180);
    cyc();
    br_taken = 1'b0;
    ID_Allow_in = 1'b1;
    look();
    chk("t4_bus", IF_to_ID_Bus, {32'h1c000180, 32'h1c000180 ^ KEY});
    cyc();
    br_taken = 1'b1;
    br_target = 32'h1c000200;
    cyc();
    br_target = 32'h1c000300;
    look();
    chk("t5_addr", 64'(inst_sram_addr), 64'h1c000300);
    cyc();
    br_taken = 1'b0;
    look();
    chk("t5_bus", IF_to_ID_Bus, {32'h1c000300, 32'h1c000300 ^ KEY});
    chk("t5_addr_n", 64'(inst_sram_addr), 64'h1c000304);
    cyc();
    look();
    chk("t5_pc_n", IF_to_ID_Bus[63:32], 64'h1c000304);
    cyc();
    reset = 1'b1;
    look();
    chk("t6_valid", 64'(IF_to_ID_Valid), 64'd0);
    chk("t6_en", 64'(inst_sram_en), 64'd0);
    cyc();
    reset = 1'b0;
    look();
    chk("t6_addr", 64'(inst_sram_addr), 64'h1c000000);
    for (int i = 0; i < 3000; i++) begin
      cyc();
      reset       = ($urandom_range(99) == 0);
      ID_Allow_in = ($urandom_range(9) < 6);
      br_taken    = ($urandom_range(9) == 0);
      br_target   = $urandom;
      br_stall    = $urandom_range(1);
    end
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
